// File: rtl/spi_flash_responder_if.sv
// SPI pins, byte-wide memory port and status outputs of the SPI flash responder.
// master = initiator/memory side, slave = responder side.
interface spi_flash_responder_if #(
    parameter int ADDR_W = 24
);
    logic              spi_cs_b;
    logic              spi_sck;
    logic              spi_mosi;
    logic              spi_miso;
    logic              spi_miso_oe;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_rd_en;
    logic [7:0]        mem_rd_data;
    logic              mem_wr_en;
    logic [7:0]        mem_wr_data;
    logic              wel;
    logic              bad_cmd;

    modport master (
        output spi_cs_b, spi_sck, spi_mosi, mem_rd_data,
        input  spi_miso, spi_miso_oe, mem_addr, mem_rd_en, mem_wr_en, mem_wr_data, wel, bad_cmd
    );

    modport slave (
        input  spi_cs_b, spi_sck, spi_mosi, mem_rd_data,
        output spi_miso, spi_miso_oe, mem_addr, mem_rd_en, mem_wr_en, mem_wr_data, wel, bad_cmd
    );
endinterface

// File: rtl/spi_flash_responder.sv
// SPI mode-0 flash target oversampled in the clk domain; serves reads/status/ID from a byte memory port.
// Define SPI_FLASH_RESP_PROGRAM_EN to add write-enable latch and page-program support.
module spi_flash_responder #(
    parameter int          ADDR_W   = 24,
    parameter logic [23:0] JEDEC_ID = 24'hEF4016
) (
    input  logic                 clk,
    input  logic                 reset_n,
    spi_flash_responder_if.slave bus
);
    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_CMD       = 3'd1,
        ST_ADDR      = 3'd2,
        ST_RD_DATA   = 3'd3,
        ST_PROG_DATA = 3'd4,
        ST_STAT      = 3'd5,
        ST_JEDEC     = 3'd6,
        ST_IGNORE    = 3'd7
    } state_t;

    localparam logic [ADDR_W-1:0] ADDR_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};

    state_t            r_state;
    logic              r_cs_meta, r_cs_sync, r_cs_prev;
    logic              r_sck_meta, r_sck_sync, r_sck_prev;
    logic              r_mosi_meta, r_mosi_sync;
    logic [2:0]        r_bit_cnt;
    logic [1:0]        r_byte_cnt;
    logic [22:0]       r_rx_sh;
    logic [7:0]        r_tx_sh;
    logic [7:0]        r_rd_buf;
    logic              r_rd_pend;
    logic              r_miso;
    logic              r_oe;
    logic              r_rd_en;
    logic              r_bad_cmd;
    logic [ADDR_W-1:0] r_mem_addr;
`ifdef SPI_FLASH_RESP_PROGRAM_EN
    logic              r_wel;
    logic              r_wr_en;
    logic [7:0]        r_wr_data;
    logic              r_is_read;
`endif

    logic              w_sck_rise, w_sck_fall, w_cs_rise, w_cs_fall;
    logic              w_tx_state;
    logic              w_wel;
    logic [23:0]       w_rx_word;
    logic [7:0]        w_rx_byte;
    logic [7:0]        w_status;
    logic [7:0]        w_tx_next;

    assign w_sck_rise = r_sck_sync & ~r_sck_prev & ~r_cs_sync;
    assign w_sck_fall = ~r_sck_sync & r_sck_prev & ~r_cs_sync;
    assign w_cs_rise  = r_cs_sync & ~r_cs_prev;
    assign w_cs_fall  = ~r_cs_sync & r_cs_prev;
    assign w_rx_word  = {r_rx_sh, r_mosi_sync};
    assign w_rx_byte  = w_rx_word[7:0];
    assign w_tx_state = (r_state == ST_RD_DATA) || (r_state == ST_STAT) || (r_state == ST_JEDEC);
    assign w_status   = {6'b000000, w_wel, 1'b0};

`ifdef SPI_FLASH_RESP_PROGRAM_EN
    assign w_wel           = r_wel;
    assign bus.mem_wr_en   = r_wr_en;
    assign bus.mem_wr_data = r_wr_data;
`else
    assign w_wel           = 1'b0;
    assign bus.mem_wr_en   = 1'b0;
    assign bus.mem_wr_data = 8'h00;
`endif
    assign bus.wel         = w_wel;
    assign bus.spi_miso    = r_miso;
    assign bus.spi_miso_oe = r_oe;
    assign bus.mem_addr    = r_mem_addr;
    assign bus.mem_rd_en   = r_rd_en;
    assign bus.bad_cmd     = r_bad_cmd;

    // Byte to present at the start of each output byte, by state.
    always_comb begin
        w_tx_next = 8'h00;
        case (r_state)
            ST_RD_DATA: w_tx_next = r_rd_buf;
            ST_STAT:    w_tx_next = w_status;
            ST_JEDEC: begin
                case (r_byte_cnt)
                    2'd0:    w_tx_next = JEDEC_ID[23:16];
                    2'd1:    w_tx_next = JEDEC_ID[15:8];
                    2'd2:    w_tx_next = JEDEC_ID[7:0];
                    default: w_tx_next = 8'h00;
                endcase
            end
            default:    w_tx_next = 8'h00;
        endcase
    end

    // Pin synchronisers and edge history. CS resets to "selected" so a CS held low
    // through reset release is not mistaken for a fresh CS fall.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_cs_meta   <= 1'b0;
            r_cs_sync   <= 1'b0;
            r_cs_prev   <= 1'b0;
            r_sck_meta  <= 1'b0;
            r_sck_sync  <= 1'b0;
            r_sck_prev  <= 1'b0;
            r_mosi_meta <= 1'b0;
            r_mosi_sync <= 1'b0;
        end else begin
            r_cs_meta   <= bus.spi_cs_b;
            r_cs_sync   <= r_cs_meta;
            r_cs_prev   <= r_cs_sync;
            r_sck_meta  <= bus.spi_sck;
            r_sck_sync  <= r_sck_meta;
            r_sck_prev  <= r_sck_sync;
            r_mosi_meta <= bus.spi_mosi;
            r_mosi_sync <= r_mosi_meta;
        end
    end

    // Protocol FSM with registered SPI and memory-port outputs.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state    <= ST_IDLE;
            r_bit_cnt  <= 3'd0;
            r_byte_cnt <= 2'd0;
            r_rx_sh    <= 23'd0;
            r_tx_sh    <= 8'h00;
            r_rd_buf   <= 8'h00;
            r_rd_pend  <= 1'b0;
            r_miso     <= 1'b0;
            r_oe       <= 1'b0;
            r_rd_en    <= 1'b0;
            r_bad_cmd  <= 1'b0;
            r_mem_addr <= {ADDR_W{1'b0}};
`ifdef SPI_FLASH_RESP_PROGRAM_EN
            r_wel      <= 1'b0;
            r_wr_en    <= 1'b0;
            r_wr_data  <= 8'h00;
            r_is_read  <= 1'b0;
`endif
        end else begin
            r_rd_en   <= 1'b0;
            r_bad_cmd <= 1'b0;
            r_rd_pend <= r_rd_en;
            r_miso    <= r_tx_sh[7];
            if (r_rd_pend) begin
                r_rd_buf <= bus.mem_rd_data;
            end
`ifdef SPI_FLASH_RESP_PROGRAM_EN
            r_wr_en <= 1'b0;
            // Page program advances only the in-page byte, after the strobe cycle.
            if (r_wr_en) begin
                r_mem_addr[7:0] <= r_mem_addr[7:0] + 8'd1;
            end
`endif
            if (w_cs_rise) begin
                r_state    <= ST_IDLE;
                r_bit_cnt  <= 3'd0;
                r_byte_cnt <= 2'd0;
                r_oe       <= 1'b0;
                r_tx_sh    <= 8'h00;
`ifdef SPI_FLASH_RESP_PROGRAM_EN
                if (r_state == ST_PROG_DATA) begin
                    r_wel <= 1'b0;
                end
`endif
            end else if (w_cs_fall && (r_state == ST_IDLE)) begin
                r_state    <= ST_CMD;
                r_bit_cnt  <= 3'd0;
                r_byte_cnt <= 2'd0;
            end else if (w_sck_rise && (r_state != ST_IDLE)) begin
                r_bit_cnt <= r_bit_cnt + 3'd1;
                r_rx_sh   <= w_rx_word[22:0];
                if (r_bit_cnt == 3'd7) begin
                    if (r_byte_cnt != 2'd3) begin
                        r_byte_cnt <= r_byte_cnt + 2'd1;
                    end
                    case (r_state)
                        ST_CMD: begin
                            r_byte_cnt <= 2'd0;
                            case (w_rx_byte)
                                8'h03: begin
`ifdef SPI_FLASH_RESP_PROGRAM_EN
                                    r_is_read <= 1'b1;
`endif
                                    r_state <= ST_ADDR;
                                end
                                8'h05: r_state <= ST_STAT;
                                8'h9F: r_state <= ST_JEDEC;
`ifdef SPI_FLASH_RESP_PROGRAM_EN
                                8'h02: begin
                                    r_is_read <= 1'b0;
                                    r_state   <= r_wel ? ST_ADDR : ST_IGNORE;
                                end
                                8'h06: begin
                                    r_wel   <= 1'b1;
                                    r_state <= ST_IGNORE;
                                end
                                8'h04: begin
                                    r_wel   <= 1'b0;
                                    r_state <= ST_IGNORE;
                                end
`endif
                                default: begin
                                    r_bad_cmd <= 1'b1;
                                    r_state   <= ST_IGNORE;
                                end
                            endcase
                        end
                        ST_ADDR: begin
                            if (r_byte_cnt == 2'd2) begin
                                r_byte_cnt <= 2'd0;
                                r_mem_addr <= w_rx_word[ADDR_W-1:0];
`ifdef SPI_FLASH_RESP_PROGRAM_EN
                                if (r_is_read) begin
                                    r_rd_en <= 1'b1;
                                    r_state <= ST_RD_DATA;
                                end else begin
                                    r_state <= ST_PROG_DATA;
                                end
`else
                                r_rd_en <= 1'b1;
                                r_state <= ST_RD_DATA;
`endif
                            end
                        end
                        ST_RD_DATA: begin
                            r_mem_addr <= r_mem_addr + ADDR_ONE;
                            r_rd_en    <= 1'b1;
                        end
`ifdef SPI_FLASH_RESP_PROGRAM_EN
                        ST_PROG_DATA: begin
                            r_wr_en   <= 1'b1;
                            r_wr_data <= w_rx_byte;
                        end
`endif
                        default: begin
                            r_state <= r_state;
                        end
                    endcase
                end
            end else if (w_sck_fall && w_tx_state) begin
                r_oe <= 1'b1;
                if (r_bit_cnt == 3'd0) begin
                    r_tx_sh <= w_tx_next;
                end else begin
                    r_tx_sh <= {r_tx_sh[6:0], 1'b0};
                end
            end
        end
    end
endmodule

// File: tb/tb_spi_flash_responder.sv
// Scoreboard bench for spi_flash_responder: drives SPI mode-0 transactions and a synchronous memory model.
module tb_spi_flash_responder;
    localparam int HALF = 6;

    logic clk = 1'b0;
    logic reset_n;

    spi_flash_responder_if #(.ADDR_W(24)) bus ();

    spi_flash_responder #(.ADDR_W(24), .JEDEC_ID(24'hEF4016)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    logic [7:0]  mem [logic [23:0]];
    logic [7:0]  rx_exp_q [$];
    logic [31:0] wr_exp_q [$];
    int n_checks  = 0;
    int n_errors  = 0;
    int wr_pushed = 0;
    int wr_seen   = 0;

    int n_bad = 0, n_oe = 0, n_rd = 0, n_rd_dbl = 0, n_wr = 0;
    logic prev_rd = 1'b0;
    logic [31:0] wr_log [0:63];

    // Synchronous byte memory: data valid the clk after mem_rd_en.
    always @(posedge clk) begin
        if (bus.mem_rd_en === 1'b1)
            bus.mem_rd_data <= mem.exists(bus.mem_addr) ? mem[bus.mem_addr] : 8'h00;
    end

    // Output monitor: counts strobes and logs writes away from the active edge.
    always @(negedge clk) begin
        if (bus.bad_cmd === 1'b1)     n_bad <= n_bad + 1;
        if (bus.spi_miso_oe === 1'b1) n_oe  <= n_oe + 1;
        if (bus.mem_rd_en === 1'b1)   n_rd  <= n_rd + 1;
        if ((bus.mem_rd_en === 1'b1) && (prev_rd === 1'b1)) n_rd_dbl <= n_rd_dbl + 1;
        if (bus.mem_wr_en === 1'b1) begin
            if (n_wr < 64) wr_log[n_wr] <= {bus.mem_addr, bus.mem_wr_data};
            n_wr <= n_wr + 1;
        end
        prev_rd <= bus.mem_rd_en;
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic spi_bits(input logic [7:0] tx, input int n, output logic [7:0] rx, output logic oe_all);
        rx = 8'h00;
        oe_all = 1'b1;
        for (int i = 7; i > 7 - n; i--) begin
            bus.spi_mosi = tx[i];
            repeat (HALF) @(negedge clk);
            rx[i] = bus.spi_miso;
            oe_all = oe_all & bus.spi_miso_oe;
            bus.spi_sck = 1'b1;
            repeat (HALF) @(negedge clk);
            bus.spi_sck = 1'b0;
        end
    endtask

    task automatic spi_byte(input logic [7:0] tx, input bit chk, input string tag);
        logic [7:0] rx;
        logic oe_all;
        spi_bits(tx, 8, rx, oe_all);
        if (chk) begin
            check_eq({tag, "_sb_pending"}, 32'(rx_exp_q.size() > 0), 32'd1);
            if (rx_exp_q.size() > 0) check_eq(tag, rx, rx_exp_q.pop_front());
            check_eq({tag, "_oe"}, oe_all, 1'b1);
        end
    endtask

    task automatic spi_begin();
        bus.spi_cs_b = 1'b0;
        repeat (4) @(negedge clk);
    endtask

    task automatic spi_end();
        repeat (4) @(negedge clk);
        bus.spi_cs_b = 1'b1;
        repeat (10) @(negedge clk);
    endtask

    task automatic one_byte_cmd(input logic [7:0] op);
        spi_begin();
        spi_byte(op, 1'b0, "op");
        spi_end();
    endtask

    task automatic exp_wr(input logic [23:0] a, input logic [7:0] d);
        wr_exp_q.push_back({a, d});
        wr_pushed++;
    endtask

    task automatic drain_writes();
        logic [31:0] e;
        while (wr_seen < n_wr) begin
            check_eq("wr_pending", 32'(wr_exp_q.size() > 0), 32'd1);
            e = (wr_exp_q.size() > 0) ? wr_exp_q.pop_front() : 32'hFFFF_FFFF;
            check_eq("wr_addr_data", wr_log[wr_seen], e);
            wr_seen++;
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check_eq({tag, "_miso"},    bus.spi_miso,    1'b0);
        check_eq({tag, "_oe"},      bus.spi_miso_oe, 1'b0);
        check_eq({tag, "_addr"},    bus.mem_addr,    24'h000000);
        check_eq({tag, "_rd_en"},   bus.mem_rd_en,   1'b0);
        check_eq({tag, "_wr_en"},   bus.mem_wr_en,   1'b0);
        check_eq({tag, "_wr_data"}, bus.mem_wr_data, 8'h00);
        check_eq({tag, "_wel"},     bus.wel,         1'b0);
        check_eq({tag, "_bad_cmd"}, bus.bad_cmd,     1'b0);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        int s_bad, s_oe, s_rd;
        logic [7:0] rx;
        logic oe_all;

        bus.spi_cs_b = 1'b1;
        bus.spi_sck  = 1'b0;
        bus.spi_mosi = 1'b0;
        reset_n      = 1'b0;
        mem[24'hFFFFFE] = 8'hA5;
        mem[24'hFFFFFF] = 8'h5A;
        mem[24'h000000] = 8'hC3;
        mem[24'h001234] = 8'h3C;
        mem[24'h001235] = 8'h96;
        mem[24'h001236] = 8'h0F;
        mem[24'h001237] = 8'hF0;
        repeat (4) @(negedge clk);
        check_reset_outputs("rst");
        reset_n = 1'b1;
        repeat (6) @(negedge clk);

        // JEDEC ID then trailing zeros
        rx_exp_q.push_back(8'hEF);
        rx_exp_q.push_back(8'h40);
        rx_exp_q.push_back(8'h16);
        rx_exp_q.push_back(8'h00);
        spi_begin();
        spi_byte(8'h9F, 1'b0, "cmd");
        for (int i = 0; i < 4; i++) spi_byte(8'h00, 1'b1, "jedec");
        spi_end();
        check_eq("jedec_oe_after_cs", bus.spi_miso_oe, 1'b0);

        // Read across the top of the address space
        rx_exp_q.push_back(8'hA5);
        rx_exp_q.push_back(8'h5A);
        rx_exp_q.push_back(8'hC3);
        s_rd = n_rd;
        spi_begin();
        spi_byte(8'h03, 1'b0, "cmd");
        spi_byte(8'hFF, 1'b0, "a2");
        spi_byte(8'hFF, 1'b0, "a1");
        spi_byte(8'hFE, 1'b0, "a0");
        for (int i = 0; i < 3; i++) spi_byte(8'h00, 1'b1, "rd_wrap");
        spi_end();
        check_eq("rd_wrap_strobes", n_rd - s_rd, 32'd4);

        // Sequential read elsewhere
        rx_exp_q.push_back(8'h3C);
        rx_exp_q.push_back(8'h96);
        rx_exp_q.push_back(8'h0F);
        rx_exp_q.push_back(8'hF0);
        spi_begin();
        spi_byte(8'h03, 1'b0, "cmd");
        spi_byte(8'h00, 1'b0, "a2");
        spi_byte(8'h12, 1'b0, "a1");
        spi_byte(8'h34, 1'b0, "a0");
        for (int i = 0; i < 4; i++) spi_byte(8'h00, 1'b1, "rd_seq");
        spi_end();

        // Status with WEL clear
        rx_exp_q.push_back(8'h00);
        rx_exp_q.push_back(8'h00);
        spi_begin();
        spi_byte(8'h05, 1'b0, "cmd");
        spi_byte(8'h00, 1'b1, "stat0");
        spi_byte(8'h00, 1'b1, "stat0");
        spi_end();

        // Unsupported opcode
        s_bad = n_bad;
        s_oe  = n_oe;
        spi_begin();
        spi_byte(8'hAB, 1'b0, "cmd");
        spi_byte(8'h00, 1'b0, "dummy");
        spi_end();
        check_eq("badop_pulse", n_bad - s_bad, 32'd1);
        check_eq("badop_oe", n_oe - s_oe, 32'd0);

`ifdef SPI_FLASH_RESP_PROGRAM_EN
        one_byte_cmd(8'h06);
        check_eq("wren_wel", bus.wel, 1'b1);
        rx_exp_q.push_back(8'h02);
        spi_begin();
        spi_byte(8'h05, 1'b0, "cmd");
        spi_byte(8'h00, 1'b1, "stat_wel");
        spi_end();

        exp_wr(24'h0001FE, 8'h11);
        exp_wr(24'h0001FF, 8'h22);
        exp_wr(24'h000100, 8'h33);
        spi_begin();
        spi_byte(8'h02, 1'b0, "cmd");
        spi_byte(8'h00, 1'b0, "a2");
        spi_byte(8'h01, 1'b0, "a1");
        spi_byte(8'hFE, 1'b0, "a0");
        spi_byte(8'h11, 1'b0, "d");
        spi_byte(8'h22, 1'b0, "d");
        spi_byte(8'h33, 1'b0, "d");
        spi_end();
        drain_writes();
        check_eq("pp_wel_cleared", bus.wel, 1'b0);
        rx_exp_q.push_back(8'h00);
        spi_begin();
        spi_byte(8'h05, 1'b0, "cmd");
        spi_byte(8'h00, 1'b1, "stat_after_pp");
        spi_end();

        // Program without write enable is ignored
        s_oe = n_oe;
        spi_begin();
        spi_byte(8'h02, 1'b0, "cmd");
        spi_byte(8'h00, 1'b0, "a2");
        spi_byte(8'h00, 1'b0, "a1");
        spi_byte(8'h60, 1'b0, "a0");
        spi_byte(8'h77, 1'b0, "d");
        spi_end();
        drain_writes();
        check_eq("nowel_oe", n_oe - s_oe, 32'd0);

        // Abort mid-byte: only the completed byte is written
        one_byte_cmd(8'h06);
        exp_wr(24'h000050, 8'hAA);
        spi_begin();
        spi_byte(8'h02, 1'b0, "cmd");
        spi_byte(8'h00, 1'b0, "a2");
        spi_byte(8'h00, 1'b0, "a1");
        spi_byte(8'h50, 1'b0, "a0");
        spi_byte(8'hAA, 1'b0, "d");
        spi_bits(8'h5F, 4, rx, oe_all);
        spi_end();
        drain_writes();
        check_eq("abort_wel_cleared", bus.wel, 1'b0);

        one_byte_cmd(8'h06);
        one_byte_cmd(8'h04);
        check_eq("wrdi_wel", bus.wel, 1'b0);
`else
        s_bad = n_bad;
        s_oe  = n_oe;
        one_byte_cmd(8'h06);
        one_byte_cmd(8'h04);
        spi_begin();
        spi_byte(8'h02, 1'b0, "cmd");
        spi_byte(8'h00, 1'b0, "a2");
        spi_byte(8'h01, 1'b0, "a1");
        spi_byte(8'hFE, 1'b0, "a0");
        spi_byte(8'h11, 1'b0, "d");
        spi_end();
        check_eq("noprog_bad_pulses", n_bad - s_bad, 32'd3);
        check_eq("noprog_oe", n_oe - s_oe, 32'd0);
        check_eq("noprog_wel", bus.wel, 1'b0);
`endif

        // Asynchronous reset in the middle of a read
        spi_begin();
        spi_byte(8'h03, 1'b0, "cmd");
        spi_byte(8'h00, 1'b0, "a2");
        spi_byte(8'h12, 1'b0, "a1");
        spi_byte(8'h34, 1'b0, "a0");
        spi_bits(8'hFF, 4, rx, oe_all);
        reset_n = 1'b0;
        #1;
        check_reset_outputs("midrst");
        repeat (3) @(negedge clk);
        s_bad = n_bad;
        s_oe  = n_oe;
        s_rd  = n_rd;
        reset_n = 1'b1;
        repeat (4) @(negedge clk);
        spi_byte(8'h03, 1'b0, "ign");
        spi_byte(8'hFF, 1'b0, "ign");
        spi_end();
        check_eq("midrst_ign_bad", n_bad - s_bad, 32'd0);
        check_eq("midrst_ign_oe", n_oe - s_oe, 32'd0);
        check_eq("midrst_ign_rd", n_rd - s_rd, 32'd0);
        rx_exp_q.push_back(8'h00);
        spi_begin();
        spi_byte(8'h05, 1'b0, "cmd");
        spi_byte(8'h00, 1'b1, "stat_after_rst");
        spi_end();

        drain_writes();
        check_eq("rx_q_empty", rx_exp_q.size(), 32'd0);
        check_eq("wr_q_empty", wr_exp_q.size(), 32'd0);
        check_eq("wr_count", n_wr, wr_pushed);
        check_eq("rd_single_cycle", n_rd_dbl, 32'd0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule

// File: doc/spi_flash_responder.md
# spi_flash_responder

SPI flash responder: the target end of the bootloader's SPI flash bus, used in simulation benches and FPGA loopback builds in place of a physical flash part. It oversamples the SPI pins (mode 0) in the system clock domain, decodes a subset of the standard flash command set, and serves reads and page programs from a byte-wide synchronous memory port.

## Interface
- ADDR_W, 24: memory address width. Received 24-bit flash addresses are truncated to the low ADDR_W bits.
- JEDEC_ID, 24'hEF4016: manufacturer/device ID returned by command 0x9F, sent MSB first.
- clk  in  1  system clock, at least 8x the SCK frequency.
- reset_n  in  1  asynchronous, active-low reset.
- spi_cs_b  in  1  chip select, active low.
- spi_sck  in  1  SPI clock, mode 0, idles low.
- spi_mosi  in  1  serial data from the initiator.
- spi_miso  out  1  serial data to the initiator.
- spi_miso_oe  out  1  MISO drive enable.
- mem_addr  out  ADDR_W  memory byte address.
- mem_rd_en  out  1  one-cycle read strobe. mem_rd_data is valid on the following clk.
- mem_rd_data  in  8  memory read data.
- mem_wr_en  out  1  one-cycle write strobe.
- mem_wr_data  out  8  memory write data.
- wel  out  1  write-enable latch.
- bad_cmd  out  1  one-cycle pulse when an unsupported opcode completes.

## Operation
- **Synchronisers:** spi_cs_b, spi_sck and spi_mosi each pass through a 2-flop synchroniser. SCK rise and fall are detected on the synchronised SCK.
- **Sampling and shifting:** MOSI is sampled on each SCK rise. MISO shifts on each SCK fall. A bit counter of 0..7 and a byte counter run while CS is low.
- **FSM states:** IDLE, CMD, ADDR, RD_DATA, PROG_DATA, STAT, JEDEC, IGNORE.
- **IDLE -> CMD:** on a synchronised CS fall.
- **CMD:** completes on the 8th SCK rise, then decodes the opcode:
  - 0x03 -> ADDR (read).
  - 0x02 -> ADDR (program) when wel=1; otherwise -> IGNORE.
  - 0x05 -> STAT.
  - 0x9F -> JEDEC.
  - 0x06 sets wel and goes -> IGNORE.
  - 0x04 clears wel and goes -> IGNORE.
  - Anything else: pulse bad_cmd and go -> IGNORE.
- **ADDR:** collects 24 bits. On the 24th SCK rise, load the address register with addr[ADDR_W-1:0]. For a read, also pulse mem_rd_en. Then go to RD_DATA or PROG_DATA.
- **RD_DATA:**
  - The byte fetched by the preceding read is loaded into the output shift register on the next SCK fall. MISO presents its MSB.
  - On the 8th SCK rise of each output byte, the address increments modulo 2^ADDR_W and mem_rd_en pulses to prefetch the next byte.
  - Reads are unbounded until CS rises.
- **PROG_DATA:**
  - On each 8th SCK rise, pulse mem_wr_en with mem_wr_data set to the received byte.
  - mem_addr = {page bits, low 8 bits}. Afterwards, only the low 8 bits increment, wrapping within the 256-byte page.
- **STAT:** repeatedly sends {6'b0, wel, 1'b0}. The BUSY bit is always 0.
- **JEDEC:** sends JEDEC_ID bytes [23:16], [15:8], [7:0], then 0x00 until CS rises.
- **IGNORE:** MISO is not driven. Holds until CS rises.
- **CS rise in any state:**
  - Return to IDLE and clear the counters.
  - Deassert spi_miso_oe.
  - Discard any partial byte; no write is issued.
  - If the command was 0x02 and it reached PROG_DATA, clear wel.
- **spi_miso_oe:** high only in RD_DATA, STAT and JEDEC, from the first SCK fall after entering the state.

## Timing
- **Reset values:** spi_miso=0, spi_miso_oe=0, mem_addr=0, mem_rd_en=0, mem_wr_en=0, mem_wr_data=0, wel=0, bad_cmd=0. FSM in IDLE.
- **Input latency:** a pin edge is acted on 3 clk after it occurs (2 synchroniser flops plus edge detect).
- **MISO update:** spi_miso updates on the clk after the fall is detected, i.e. 4 clk after the pin SCK falls. At 8x oversampling this is valid before the next SCK rise.
- **Read data capture:** mem_rd_data is captured 1 clk after mem_rd_en.
- **Prefetch window:** the prefetch issued at a rise completes before the following fall, which is at least 4 clk later.
- **Strobes:** mem_wr_en, mem_rd_en and bad_cmd are single-cycle. mem_addr and mem_wr_data are stable in the strobe cycle.
- **Asynchronous reset mid-transfer:** all state returns to the reset values immediately. Subsequent SCK edges are ignored until a fresh CS fall.
- **SCK edges while CS is high:** ignored.

## Configuration
- SPI_FLASH_RESP_PROGRAM_EN defined: opcodes 0x06, 0x04 and 0x02 behave as described above.
- Not defined:
  - 0x06, 0x04 and 0x02 are treated as unsupported: bad_cmd pulses and the FSM goes to IGNORE.
  - wel is tied 0 and mem_wr_en is tied 0.
  - The PROG_DATA logic is removed.

## Test plan
- **JEDEC read:** 0x9F then 4 dummy bytes -> MISO returns EF, 40, 16, 00; spi_miso_oe is 0 after CS rises.
- **Read with address wrap:** memory preloaded with mem[0xFFFFFE]=A5 and mem[0xFFFFFF]=5A, mem[0]=C3 (ADDR_W=24); send 0x03 FFFFFE and read 3 bytes -> A5, 5A, C3.
- **Program with page wrap:** send 0x06 (CS rise), then 0x02 0001FE with data 11 22 33 -> writes to 0x1FE, 0x1FF, 0x100; a following 0x05 returns 0x00.
- **Program without write enable:** 0x02 with no preceding 0x06 -> no mem_wr_en and MISO undriven; status reads 0x00.
- **Aborts and bad opcode:** CS rises after 4 data bits of a program byte -> no write; opcode 0xAB -> one bad_cmd pulse and spi_miso_oe stays 0.
- **Reset mid-read:** reset_n asserted mid-read -> all outputs at reset values on the same clk; the next 0x05 transaction works normally.
